gio_outport: RTL and testbench
==============================

Name: gio_outport

Overview:
- Single addressed output-port register on the processor general-purpose I/O bus.
- Captures `value_in` when a write strobe targets its configured port address, and drives the stored value continuously on `port_out`.
- Multiple instances with distinct `ADDR` share one `address`/`value_in`/`wen` bus; each instance decodes only its own address.

Parameters:
- ADDR, 8'h01, port address this instance responds to (compared against all 8 address bits).
- WIDTH, 8, width of `value_in`/`port_out`.
- RST_VAL, {WIDTH{1'b0}}, value loaded into the port register on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on rising `clk`).
- address  input  8  I/O bus port address.
- value_in  input  WIDTH  I/O bus write data.
- wen  input  1  I/O bus write enable, active-high, level-sampled each clock.
- port_out  output  WIDTH  registered port value.
- port_strobe  output  1  one-cycle pulse, registered; high in the cycle after `port_out` was written.

Behaviour:
- Reset (rst==0 at clk edge): `port_out` <= RST_VAL, `port_strobe` <= 0. Reset overrides any simultaneous write.
- Address hit: `hit = (address == ADDR)`, full 8-bit equality, combinational.
- Write: at clk edge with rst==1, wen==1, hit==1: `port_out` <= `value_in`; `port_strobe` <= 1.
- Otherwise `port_out` holds its value; `port_strobe` <= 0.
- Latency: `port_out` reflects new data one clock after the sampled write edge; no combinational path from inputs to outputs.
- `wen` held high across N cycles with a matching address: register rewritten every cycle (last value wins); `port_strobe` stays high for those N cycles.
- Address change while `wen` is high: only cycles with a hit write.
- `wen` with a non-matching address: no change, no strobe.
- X/unknown `address` while `wen` is low: no effect.
- Reset mid-operation: outputs return to reset values on the next edge; normal operation resumes the first edge after rst==1.

Optional Feature:
- Macro: `OUTPORT_READBACK_EN`.
- When defined, adds inputs `ren` (1 bit) and outputs `read_data` (WIDTH) and `read_valid` (1 bit).
  - At a clk edge with ren==1 and hit==1: `read_data` <= `port_out` (pre-write value if a write occurs the same cycle) and `read_valid` <= 1.
  - Otherwise `read_data` <= 0 and `read_valid` <= 0, so the bus can be OR-combined across instances.
  - Both outputs reset to 0.
- When not defined, these ports and their logic do not exist; write behaviour is identical in both builds.

Decomposition:
- Shared package `gio_pkg`:
  - `IO_ADDR_W` = 8.
  - `IO_DATA_W` = 8.
  - typedefs `io_addr_t` / `io_data_t`.
  - default port address constants.
- One natural sub-module: `gio_addr_match` (parameterised comparator producing `hit`), reusable by the matching input-port block.

Test Plan:
- Reset: drive rst=0 for 2 cycles with wen=1, address=8'h01, value_in=8'hAA -> `port_out`==8'h00 and `port_strobe`==0 throughout.
- Matching write: ADDR=8'h01; address=8'h01, value_in=8'hAA, wen=1 for one cycle -> next cycle `port_out`==8'hAA, `port_strobe` high exactly one cycle.
- Non-matching write: address=8'h10, value_in=8'h05, wen=1 -> `port_out` stays 8'hAA, `port_strobe`==0.
- No enable: address=8'h01, value_in=8'h55, wen=0 for 5 cycles -> `port_out` stays 8'hAA.
- Held enable: address=8'h01, wen=1 for 3 cycles with value_in 8'h11, 8'h22, 8'h33 -> `port_out` follows one cycle later and ends at 8'h33; `port_strobe` high 3 cycles.
- Reset mid-operation plus readback (`OUTPORT_READBACK_EN`):
  - rst=0 while `port_out`==8'h33 -> 8'h00 next edge.
  - Then write 8'hAA, then ren=1 at address 8'h01 -> `read_data`==8'hAA with `read_valid`==1.
  - ren=1 at address 8'h10 -> `read_data`==8'h00, `read_valid`==0.

Source files
------------

// File: rtl/gio_pkg.sv
// Shared definitions for the general-purpose I/O bus: widths, types and default port addresses.
package gio_pkg;

    localparam int IO_ADDR_W = 8;
    localparam int IO_DATA_W = 8;

    typedef logic [IO_ADDR_W-1:0] io_addr_t;
    typedef logic [IO_DATA_W-1:0] io_data_t;

    localparam io_addr_t DEFAULT_OUT_ADDR = 8'h01;
    localparam io_addr_t DEFAULT_IN_ADDR  = 8'h00;

endpackage

// File: rtl/gio_addr_match.sv
// Full-width port address comparator, shared by the input and output port blocks.
module gio_addr_match
    import gio_pkg::*;
#(
    parameter io_addr_t ADDR = DEFAULT_OUT_ADDR
) (
    input  io_addr_t address,
    output logic     hit
);

    assign hit = (address == ADDR);

endmodule

// File: rtl/gio_outport.sv
// Addressed output-port register on the GPIO bus; optional readback path under OUTPORT_READBACK_EN.
module gio_outport
    import gio_pkg::*;
#(
    parameter io_addr_t         ADDR    = DEFAULT_OUT_ADDR,
    parameter int               WIDTH   = IO_DATA_W,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  io_addr_t         address,
    input  logic [WIDTH-1:0] value_in,
    input  logic             wen,
`ifdef OUTPORT_READBACK_EN
    input  logic             ren,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
`endif
    output logic [WIDTH-1:0] port_out,
    output logic             port_strobe
);

    logic             w_hit;
    logic             w_write;
    logic [WIDTH-1:0] r_port;
    logic             r_strobe;

    gio_addr_match #(.ADDR(ADDR)) u_match (
        .address (address),
        .hit     (w_hit)
    );

    assign w_write = wen && w_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_port   <= RST_VAL;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_write;
            if (w_write) begin
                r_port <= value_in;
            end
        end
    end

    assign port_out    = r_port;
    assign port_strobe = r_strobe;

`ifdef OUTPORT_READBACK_EN
    logic [WIDTH-1:0] r_read_data;
    logic             r_read_valid;

    // Non-selected instances drive zero so several ports can be OR-combined onto one read bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else if (ren && w_hit) begin
            r_read_data  <= r_port;
            r_read_valid <= 1'b1;
        end else begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
`endif

endmodule

// File: tb/tb_gio_outport.sv
// Scoreboard bench for gio_outport: a reference model queues expected outputs per edge, a monitor compares them.
module tb_gio_outport;

    localparam logic [7:0] PORT_ADDR = 8'h01;
    localparam logic [7:0] RESET_VAL = 8'h00;

    logic       clk;
    logic       rst;
    logic [7:0] address;
    logic [7:0] value_in;
    logic       wen;
    logic       ren;
    logic [7:0] port_out;
    logic       port_strobe;
`ifdef OUTPORT_READBACK_EN
    logic [7:0] read_data;
    logic       read_valid;
`endif

    typedef struct {
        logic [7:0] port;
        logic       strobe;
        logic [7:0] rdata;
        logic       rvalid;
    } expect_t;

    expect_t    expQ[$];
    logic [7:0] modelPort;
    int         checks;
    int         errors;

    gio_outport #(
        .ADDR    (PORT_ADDR),
        .WIDTH   (8),
        .RST_VAL (RESET_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .value_in    (value_in),
        .wen         (wen),
`ifdef OUTPORT_READBACK_EN
        .ren         (ren),
        .read_data   (read_data),
        .read_valid  (read_valid),
`endif
        .port_out    (port_out),
        .port_strobe (port_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a port that remembers the last value written to its address since reset.
    always @(posedge clk) begin
        expect_t e;
        e.rdata  = 8'h00;
        e.rvalid = 1'b0;
        if (rst === 1'b0) begin
            modelPort = RESET_VAL;
            e.strobe  = 1'b0;
        end else begin
            if (ren === 1'b1 && address === PORT_ADDR) begin
                e.rdata  = modelPort;
                e.rvalid = 1'b1;
            end
            if (wen === 1'b1 && address === PORT_ADDR) begin
                modelPort = value_in;
                e.strobe  = 1'b1;
            end else begin
                e.strobe = 1'b0;
            end
        end
        e.port = modelPort;
        expQ.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one expected entry is consumed per edge.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("port_out", {24'h0, port_out}, {24'h0, e.port});
            checkOutput("port_strobe", {31'h0, port_strobe}, {31'h0, e.strobe});
`ifdef OUTPORT_READBACK_EN
            checkOutput("read_data", {24'h0, read_data}, {24'h0, e.rdata});
            checkOutput("read_valid", {31'h0, read_valid}, {31'h0, e.rvalid});
`endif
        end
    end

    task automatic applyStimulus(input logic rstV, input logic [7:0] addrV,
                                 input logic [7:0] dataV, input logic wenV, input logic renV);
        @(negedge clk);
        rst      = rstV;
        address  = addrV;
        value_in = dataV;
        wen      = wenV;
        ren      = renV;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] heldVals [3];
        checks   = 0;
        errors   = 0;
        modelPort = RESET_VAL;
        rst      = 1'b0;
        address  = 8'h00;
        value_in = 8'h00;
        wen      = 1'b0;
        ren      = 1'b0;
        heldVals = '{8'h11, 8'h22, 8'h33};

        $display("[TB] reset with a matching write pending");
        applyStimulus(1'b0, PORT_ADDR, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b0, PORT_ADDR, 8'hAA, 1'b1, 1'b0);

        $display("[TB] directed write sequence");
        applyStimulus(1'b1, PORT_ADDR, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h10, 8'h05, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, PORT_ADDR, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hxx, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, PORT_ADDR, heldVals[i], 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("[TB] reset mid-operation and readback");
        applyStimulus(1'b0, PORT_ADDR, 8'h99, 1'b1, 1'b0);
        applyStimulus(1'b1, PORT_ADDR, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b1, PORT_ADDR, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h10, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, PORT_ADDR, 8'h3C, 1'b1, 1'b1);
        applyStimulus(1'b1, PORT_ADDR, 8'h00, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = PORT_ADDR;
                2:       a = 8'h10;
                default: a = 8'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 29) != 0), a, 8'($urandom),
                          1'($urandom), 1'($urandom));
        end

        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
